// File: rtl/sample_frame_loader.sv
// Byte-serial frame assembler with a double-buffered dispatch register that
// streams one channel sample per ready/valid beat.
module sample_frame_loader #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [7:0]            byte_in,
  input  logic                  byte_wr,
  input  logic                  frame_go,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_chan,
  output logic                  frame_done,
  output logic [3:0]            byte_count,
  output logic                  busy,
  output logic [1:0]            err
);

  localparam int         BYTES      = NUM_CHANNELS * DATA_WIDTH / 8;
  localparam int         FRAME_W    = BYTES * 8;
  localparam logic [3:0] FULL_COUNT = 4'(BYTES);
  localparam logic [1:0] LAST_CHAN  = 2'(NUM_CHANNELS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state, state_next;

  logic [FRAME_W-1:0] asm_reg;
  logic [FRAME_W-1:0] dispatch_reg;
  logic [FRAME_W-1:0] asm_shift;
  logic [FRAME_W-1:0] asm_first;
  logic               full;
  logic               go_accept;
  logic               beat;
  logic               last_beat;

  assign full      = (byte_count == FULL_COUNT);
  // frame_go is judged against the count before any same-cycle byte write
  assign go_accept = ena && frame_go && (state == IDLE) && full;
  assign beat      = ena && (state == SEND) && out_ready;
  assign last_beat = beat && (out_chan == LAST_CHAN);

  always_comb begin
    asm_shift       = asm_reg << 8;
    asm_shift[7:0]  = byte_in;
    asm_first       = '0;
    asm_first[7:0]  = byte_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (go_accept) state_next = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_reg      <= '0;
      dispatch_reg <= '0;
      byte_count   <= '0;
      out_chan     <= '0;
      frame_done   <= 1'b0;
      err          <= '0;
    end else if (ena) begin
      frame_done <= last_beat;

      if (go_accept) begin
        dispatch_reg <= asm_reg;
        out_chan     <= '0;
      end else if (beat) begin
        out_chan <= last_beat ? 2'd0 : out_chan + 2'd1;
      end

      // A byte arriving with an accepted go starts the next frame
      if (go_accept) begin
        byte_count <= byte_wr ? 4'd1 : 4'd0;
        if (byte_wr) asm_reg <= asm_first;
      end else if (byte_wr) begin
        if (!full) begin
          asm_reg    <= asm_shift;
          byte_count <= byte_count + 4'd1;
        end else begin
          err[0] <= 1'b1;
        end
      end

      if (frame_go && (state == IDLE) && !full) err[1] <= 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (out_chan == 2'(i)) out_data = dispatch_reg[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_sample_frame_loader.sv
// Self-checking bench for sample_frame_loader: vector table, directed corner
// sequences and random traffic compared against a queue-based reference model.
module tb_sample_frame_loader;

  localparam int NC  = 4;
  localparam int DW  = 16;
  localparam int NB  = NC * DW / 8;
  localparam int BPC = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_wr = 1'b0;
  logic          frame_go = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_chan;
  logic          frame_done;
  logic [3:0]    byte_count;
  logic          busy;
  logic [1:0]    err;

  always #5 clk = ~clk;

  sample_frame_loader #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .byte_in(byte_in), .byte_wr(byte_wr),
    .frame_go(frame_go), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_chan(out_chan), .frame_done(frame_done),
    .byte_count(byte_count), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending bytes and pending beats as queues
  typedef struct {
    logic [1:0]    chan;
    logic [DW-1:0] data;
  } beat_t;

  logic [7:0] m_bytes[$];
  beat_t      m_beats[$];
  logic       m_done;
  logic [1:0] m_err;

  function automatic void model_reset();
    m_bytes.delete();
    m_beats.delete();
    m_done = 1'b0;
    m_err  = 2'b00;
  endfunction

  function automatic void model_step(bit e, bit w, logic [7:0] b, bit g, bit r);
    int    pre;
    bit    idle, acc, fd;
    beat_t bt;
    if (!e) return;
    pre  = m_bytes.size();
    idle = (m_beats.size() == 0);
    acc  = g && idle && (pre == NB);
    fd   = !idle && r && (m_beats.size() == 1);
    if (!idle && r) void'(m_beats.pop_front());
    if (g && idle && pre < NB) m_err[1] = 1'b1;
    if (acc) begin
      for (int c = 0; c < NC; c++) begin
        bt.chan = 2'(c);
        bt.data = '0;
        for (int k = 0; k < BPC; k++)
          bt.data = (bt.data << 8) | DW'(m_bytes[(NC-1-c)*BPC + k]);
        m_beats.push_back(bt);
      end
      m_bytes.delete();
      if (w) m_bytes.push_back(b);
    end else if (w) begin
      if (pre < NB) m_bytes.push_back(b);
      else m_err[0] = 1'b1;
    end
    m_done = fd;
  endfunction

  task automatic compare_model(input string tag);
    chk({tag, ".byte_count"}, 32'(byte_count), 32'(m_bytes.size()));
    chk({tag, ".out_valid"},  32'(out_valid),  32'(m_beats.size() > 0));
    chk({tag, ".busy"},       32'(busy),       32'(m_beats.size() > 0));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(m_done));
    chk({tag, ".err"},        32'(err),        32'(m_err));
    if (m_beats.size() > 0) begin
      chk({tag, ".out_chan"}, 32'(out_chan), 32'(m_beats[0].chan));
      chk({tag, ".out_data"}, 32'(out_data), 32'(m_beats[0].data));
    end
  endtask

  task automatic step(input bit e, input bit w, input logic [7:0] b, input bit g, input bit r);
    ena = e; byte_wr = w; byte_in = b; frame_go = g; out_ready = r;
    @(posedge clk);
    model_step(e, w, b, g, r);
    #1;
    compare_model("model");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid",  32'(out_valid),  32'd0);
    chk("rst.out_data",   32'(out_data),   32'd0);
    chk("rst.out_chan",   32'(out_chan),   32'd0);
    chk("rst.frame_done", 32'(frame_done), 32'd0);
    chk("rst.byte_count", 32'(byte_count), 32'd0);
    chk("rst.busy",       32'(busy),       32'd0);
    chk("rst.err",        32'(err),        32'd0);
    ena = 1'b0; byte_wr = 1'b0; frame_go = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  logic [7:0] fb [NB];

  task automatic write_frame();
    for (int i = 0; i < NB; i++) step(1, 1, fb[i], 0, 1);
  endtask

  typedef struct {
    bit         e, w, g, r;
    logic [7:0] b;
    int         cnt;
    bit         vld;
    int         chan;
    logic [15:0] data;
    bit         done;
    logic [1:0] err;
  } vec_t;

  function automatic vec_t mk(bit e, bit w, bit g, bit r, logic [7:0] b, int cnt,
                              bit vld, int chan, logic [15:0] data, bit done, logic [1:0] err);
    vec_t v;
    v.e = e; v.w = w; v.g = g; v.r = r; v.b = b; v.cnt = cnt; v.vld = vld;
    v.chan = chan; v.data = data; v.done = done; v.err = err;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    fb = '{8'h00, 8'h04, 8'h00, 8'h03, 8'h00, 8'h02, 8'h00, 8'h01};
    // Basic frame with out_ready held high
    tbl[0]  = mk(1, 1, 0, 1, 8'h00, 1, 0, 0, 16'h0000, 0, 2'b00);
    tbl[1]  = mk(1, 1, 0, 1, 8'h04, 2, 0, 0, 16'h0000, 0, 2'b00);
    tbl[2]  = mk(1, 1, 0, 1, 8'h00, 3, 0, 0, 16'h0000, 0, 2'b00);
    tbl[3]  = mk(1, 1, 0, 1, 8'h03, 4, 0, 0, 16'h0000, 0, 2'b00);
    tbl[4]  = mk(1, 1, 0, 1, 8'h00, 5, 0, 0, 16'h0000, 0, 2'b00);
    tbl[5]  = mk(1, 1, 0, 1, 8'h02, 6, 0, 0, 16'h0000, 0, 2'b00);
    tbl[6]  = mk(1, 1, 0, 1, 8'h00, 7, 0, 0, 16'h0000, 0, 2'b00);
    tbl[7]  = mk(1, 1, 0, 1, 8'h01, 8, 0, 0, 16'h0000, 0, 2'b00);
    tbl[8]  = mk(1, 0, 1, 1, 8'h00, 0, 1, 0, 16'h0001, 0, 2'b00);
    tbl[9]  = mk(1, 0, 0, 1, 8'h00, 0, 1, 1, 16'h0002, 0, 2'b00);
    tbl[10] = mk(1, 0, 0, 1, 8'h00, 0, 1, 2, 16'h0003, 0, 2'b00);
    tbl[11] = mk(1, 0, 0, 1, 8'h00, 0, 1, 3, 16'h0004, 0, 2'b00);
    tbl[12] = mk(1, 0, 0, 1, 8'h00, 0, 0, 0, 16'h0000, 1, 2'b00);
    tbl[13] = mk(1, 0, 0, 1, 8'h00, 0, 0, 0, 16'h0000, 0, 2'b00);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].e, tbl[i].w, tbl[i].b, tbl[i].g, tbl[i].r);
      chk($sformatf("vec%0d.byte_count", i), 32'(byte_count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.out_valid", i),  32'(out_valid),  32'(tbl[i].vld));
      chk($sformatf("vec%0d.frame_done", i), 32'(frame_done), 32'(tbl[i].done));
      chk($sformatf("vec%0d.err", i),        32'(err),        32'(tbl[i].err));
      if (tbl[i].vld) begin
        chk($sformatf("vec%0d.out_chan", i), 32'(out_chan), 32'(tbl[i].chan));
        chk($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(tbl[i].data));
      end
      $display("vector %0d: wr=%0b byte=%02h go=%0b -> count=%0d valid=%0b chan=%0d data=%04h done=%0b",
               i, tbl[i].w, tbl[i].b, tbl[i].g, byte_count, out_valid, out_chan, out_data, frame_done);
    end

    // Back-pressure on channel 2
    do_reset();
    write_frame();
    step(1, 0, 8'h00, 1, 1);
    step(1, 0, 8'h00, 0, 1);
    step(1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'h00, 0, 0);
      chk("stall.out_chan", 32'(out_chan), 32'd2);
      chk("stall.out_data", 32'(out_data), 32'h0003);
      chk("stall.out_valid", 32'(out_valid), 32'd1);
    end
    step(1, 0, 8'h00, 0, 1);
    chk("stall.resume_chan", 32'(out_chan), 32'd3);
    step(1, 0, 8'h00, 0, 1);
    chk("stall.frame_done", 32'(frame_done), 32'd1);
    $display("sequence stall: channel 2 held under back-pressure");

    // Overflow: ninth byte dropped
    do_reset();
    write_frame();
    step(1, 1, 8'hEE, 0, 1);
    chk("ovf.byte_count", 32'(byte_count), 32'd8);
    chk("ovf.err", 32'(err), 32'b01);
    step(1, 0, 8'h00, 1, 1);
    chk("ovf.first_data", 32'(out_data), 32'h0001);
    repeat (5) step(1, 0, 8'h00, 0, 1);
    $display("sequence overflow: err=%02b", err);

    // Short frame go
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, fb[i], 0, 1);
    step(1, 0, 8'h00, 1, 1);
    chk("short.out_valid", 32'(out_valid), 32'd0);
    chk("short.err", 32'(err), 32'b10);
    chk("short.byte_count", 32'(byte_count), 32'd5);
    $display("sequence short go: err=%02b count=%0d", err, byte_count);

    // Byte write coinciding with an accepted go, then reset mid-send
    do_reset();
    write_frame();
    step(1, 1, 8'hAA, 1, 1);
    chk("wrgo.byte_count", 32'(byte_count), 32'd1);
    chk("wrgo.out_data", 32'(out_data), 32'h0001);
    step(1, 0, 8'h00, 0, 1);
    chk("wrgo.out_chan", 32'(out_chan), 32'd1);
    do_reset();
    $display("sequence write+go and reset mid-send");

    // Enable low mid-send
    do_reset();
    write_frame();
    step(1, 0, 8'h00, 1, 1);
    step(1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h55, 1, 1);
      chk("ena.out_chan", 32'(out_chan), 32'd1);
      chk("ena.byte_count", 32'(byte_count), 32'd0);
      chk("ena.frame_done", 32'(frame_done), 32'd0);
    end
    repeat (4) step(1, 0, 8'h00, 0, 1);
    $display("sequence enable freeze: resumed, done=%0b", frame_done);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, 8'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7);
    end
    $display("random traffic: 3000 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
